// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Handshake bundle between the per-channel TX FIFOs, the shared
//                transmit serializer and the round-robin arbiter.
//                slave modport = arbiter side, master modport = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    localparam int IDW = $clog2(NCH);

    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    lock;
    logic [NCH-1:0]    ack;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_done;
    logic [IDW-1:0]    grant_id;
    logic              active;
    logic              err_to;

    modport slave (
        input  req, data, lock, tx_done,
        output ack, tx_start, tx_data, grant_id, active, err_to
    );

    modport master (
        output req, data, lock, tx_done,
        input  ack, tx_start, tx_data, grant_id, active, err_to
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one UART TX serializer between
//                NCH byte requesters. Issues a one-cycle start pulse with the
//                granted byte and waits for tx_done (or a timeout) before the
//                next grant. Optional burst lock: define UART_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    uart_tx_arbiter_if.slave    bus
);
    localparam int IDW = $clog2(NCH);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] c_TLAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [IDW-1:0] c_RR_RST = IDW'(NCH - 1);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_DONE = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [NCH-1:0]  r_ack, w_ack_nxt;
    logic            r_tx_start, w_tx_start_nxt;
    logic [DW-1:0]   r_tx_data, w_tx_data_nxt;
    logic [IDW-1:0]  r_grant_id, w_grant_nxt;
    logic            r_active, w_active_nxt;
    logic            r_err_to, w_err_nxt;
    logic [IDW-1:0]  r_rr_ptr, w_rr_nxt;
    logic [TW-1:0]   r_timer, w_timer_nxt;

    logic            w_rr_found;
    logic [IDW-1:0]  w_rr_pick;
    logic            w_lock_hit;
    logic            w_gnt_vld;
    logic [IDW-1:0]  w_gnt_id;
    logic [DW-1:0]   w_gnt_data;
    logic [NCH-1:0]  w_gnt_onehot;

    // First requester after the pointer, searching ptr+1, ptr+2, ... mod NCH
    function automatic logic [IDW:0] f_rr_pick(input logic [NCH-1:0] req,
                                                input logic [IDW-1:0] ptr);
        logic           found;
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        int             sum;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NCH; k++) begin
            sum = (int'(ptr) + k) % NCH;
            idx = IDW'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    // Round-robin candidate for the current pointer
    always_comb begin
        {w_rr_found, w_rr_pick} = f_rr_pick(bus.req, r_rr_ptr);
    end

`ifdef UART_ARB_LOCK_EN
    // Set only for the IDLE cycle that follows a frame ended by tx_done
    logic r_burst;

    // Track whether the previous frame completed normally (timeout breaks bursts)
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_burst <= 1'b0;
        else if (r_state == S_WAIT_DONE)
            r_burst <= bus.tx_done;
        else
            r_burst <= 1'b0;
    end

    // Burst continuation: same channel still locked and requesting
    always_comb begin
        w_lock_hit = r_burst && bus.lock[r_grant_id] && bus.req[r_grant_id];
    end
`else
    // Lock input has no effect without the burst feature
    wire w_unused_lock = &{1'b0, bus.lock};

    // Pure round robin: never a lock regrant
    always_comb begin
        w_lock_hit = 1'b0;
    end
`endif

    // Select the channel to grant, its byte and its one-hot ack
    always_comb begin
        w_gnt_vld    = w_lock_hit | w_rr_found;
        w_gnt_id     = w_lock_hit ? r_grant_id : w_rr_pick;
        w_gnt_data   = '0;
        w_gnt_onehot = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_gnt_data      = bus.data[i*DW +: DW];
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = '0;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_grant_nxt    = r_grant_id;
        w_active_nxt   = r_active;
        w_err_nxt      = 1'b0;
        w_rr_nxt       = r_rr_ptr;
        w_timer_nxt    = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_vld) begin
                    w_ack_nxt      = w_gnt_onehot;
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = w_gnt_data;
                    w_grant_nxt    = w_gnt_id;
                    w_active_nxt   = 1'b1;
                    w_timer_nxt    = '0;
                    w_state_nxt    = S_WAIT_DONE;
                    // A lock regrant reuses the current channel; pointer stays put
                    if (!w_lock_hit)
                        w_rr_nxt = w_rr_pick;
                end
            end
            S_WAIT_DONE: begin
                w_timer_nxt = r_timer + 1'b1;
                if (bus.tx_done) begin
                    w_active_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if ((TIMEOUT != 0) && (r_timer == c_TLAST)) begin
                    w_err_nxt    = 1'b1;
                    w_active_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_active   <= 1'b0;
            r_err_to   <= 1'b0;
            r_rr_ptr   <= c_RR_RST;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= w_ack_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_grant_id <= w_grant_nxt;
            r_active   <= w_active_nxt;
            r_err_to   <= w_err_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.grant_id = r_grant_id;
    assign bus.active   = r_active;
    assign bus.err_to   = r_err_to;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter
//                (NCH=4, DW=8, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    uart_tx_arbiter_if #(.NCH(NCH), .DW(DW)) u_if ();

    uart_tx_arbiter #(
        .NCH     (NCH),
        .DW      (DW),
        .TIMEOUT (16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_done();
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
    endtask

    logic [1:0] exp_seq1 [5];
    logic [1:0] exp_seq5 [4];

    initial begin
        checks   = 0;
        failures = 0;
        exp_seq1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef UART_ARB_LOCK_EN
        exp_seq5 = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
        exp_seq5 = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
        rst_n        = 1'b0;
        u_if.req     = 4'b1111;
        u_if.data    = {8'h44, 8'h33, 8'h22, 8'h11};
        u_if.lock    = 4'b0000;
        u_if.tx_done = 1'b0;
        tick();
        tick();

        // Reset state with all requests asserted
        check("rst_ack",      u_if.ack,      4'b0000);
        check("rst_tx_start", u_if.tx_start, 1'b0);
        check("rst_active",   u_if.active,   1'b0);
        check("rst_grant_id", u_if.grant_id, 2'd0);
        check("rst_tx_data",  u_if.tx_data,  8'h00);
        check("rst_err_to",   u_if.err_to,   1'b0);

        // Round robin with all requests high: 0,1,2,3,0
        rst_n = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) begin
            check("rr_ack",      u_if.ack,      4'b0001 << exp_seq1[n]);
            check("rr_grant_id", u_if.grant_id, exp_seq1[n]);
            check("rr_tx_data",  u_if.tx_data,  8'h11 * (exp_seq1[n] + 1));
            check("rr_tx_start", u_if.tx_start, 1'b1);
            tick();
            check("rr_start_pulse", u_if.tx_start, 1'b0);
            check("rr_ack_pulse",   u_if.ack,      4'b0000);
            tick();
            tick();
            check("rr_active_wait", u_if.active, 1'b1);
            send_done();
            check("rr_active_done", u_if.active,   1'b0);
            check("rr_idle_gap",    u_if.tx_start, 1'b0);
            tick();
        end
        // Sixth grant (channel 1) in flight; stop requesting and finish it
        check("rr_sixth", u_if.grant_id, 2'd1);
        u_if.req = 4'b0000;
        tick();
        send_done();

        // Single requester on channel 2 with byte A5
        u_if.req  = 4'b0100;
        u_if.data = {8'h44, 8'hA5, 8'h22, 8'h11};
        check("lat_pre_ack", u_if.ack, 4'b0000);
        tick();
        check("ch2_ack",      u_if.ack,      4'b0100);
        check("ch2_tx_start", u_if.tx_start, 1'b1);
        check("ch2_tx_data",  u_if.tx_data,  8'hA5);
        check("ch2_grant_id", u_if.grant_id, 2'd2);
        u_if.req = 4'b0000;
        for (int i = 0; i < 10; i++) tick();
        check("ch2_active_mid", u_if.active, 1'b1);
        send_done();
        check("ch2_active_done", u_if.active,   1'b0);
        check("ch2_data_hold",   u_if.tx_data,  8'hA5);
        check("ch2_grant_hold",  u_if.grant_id, 2'd2);

        // tx_done while idle has no effect
        send_done();
        check("idle_done_start", u_if.tx_start, 1'b0);
        check("idle_done_err",   u_if.err_to,   1'b0);

        // Timeout on channel 0, then round robin skips it
        u_if.req = 4'b0001;
        tick();
        check("to_grant0", u_if.grant_id, 2'd0);
        check("to_start",  u_if.tx_start, 1'b1);
        u_if.req = 4'b0101;
        for (int i = 0; i < 15; i++) tick();
        check("to_err_early",    u_if.err_to, 1'b0);
        check("to_active_early", u_if.active, 1'b1);
        tick();
        check("to_err_pulse",  u_if.err_to, 1'b1);
        check("to_active_off", u_if.active, 1'b0);
        tick();
        check("to_err_clear",  u_if.err_to,   1'b0);
        check("to_next_grant", u_if.grant_id, 2'd2);
        check("to_next_ack",   u_if.ack,      4'b0100);

        // tx_done coincident with timeout expiry: no error
        for (int i = 0; i < 15; i++) tick();
        u_if.req = 4'b0001;
        send_done();
        check("tie_err",    u_if.err_to, 1'b0);
        check("tie_active", u_if.active, 1'b0);
        tick();
        check("tie_regrant", u_if.grant_id, 2'd0);
        u_if.req = 4'b0000;

        // Reset in the middle of a frame
        tick();
        tick();
        rst_n    = 1'b0;
        u_if.req = 4'b1111;
        tick();
        check("mrst_active",   u_if.active,   1'b0);
        check("mrst_ack",      u_if.ack,      4'b0000);
        check("mrst_start",    u_if.tx_start, 1'b0);
        check("mrst_tx_data",  u_if.tx_data,  8'h00);
        tick();
        check("mrst_ack_hold", u_if.ack, 4'b0000);
        rst_n    = 1'b1;
        u_if.req = 4'b0000;
        tick();

        // Burst lock on channel 1 (alternates when the feature is absent)
        u_if.req = 4'b0001;
        tick();
        check("lk_pre_grant", u_if.grant_id, 2'd0);
        u_if.req  = 4'b0011;
        u_if.lock = 4'b0010;
        tick();
        send_done();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lk_grant", u_if.grant_id, exp_seq5[i]);
            if (i == 2) u_if.lock = 4'b0000;
            tick();
            send_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
